// File: rtl/wos_kernel_mem_master.sv
`default_nettype none
// ============================================================================
// Module   : wos_kernel_mem_master
// Purpose  : Kernel-side memory master. Walks every pixel of a WxH 8-bit
//            image, fetches the masked NxN clamp-to-edge window, streams the
//            enabled bytes to the rank/sort datapath and writes the returned
//            byte to the destination image.
// Revision : 1.0 - initial release
// ============================================================================
module wos_kernel_mem_master #(
  parameter int          MAX_N    = 5,
  parameter logic [31:0] SRC_BASE = 32'h0000_0100,
  parameter logic [31:0] DST_BASE = 32'h0000_0200
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_start,
  input  logic [31:0]              i_parameters,
  input  logic [MAX_N*MAX_N-1:0]   i_mask,
  input  logic [7:0]               i_mem_data,
  output logic                     o_running,
  output logic [31:0]              o_mem_addr,
  output logic                     o_mem_w_en,
  output logic [7:0]               o_mem_w_data,
  output logic                     o_pix_valid,
  output logic [7:0]               o_pix_data,
  output logic                     o_pix_last,
  input  logic                     i_pix_ready,
  input  logic                     i_res_valid,
  input  logic [7:0]               i_res_data,
  output logic                     o_done,
  output logic                     o_err
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CHECK    = 3'd1,
    S_FETCH    = 3'd2,
    S_PRESENT  = 3'd3,
    S_WAIT_RES = 3'd4,
    S_WRITE    = 3'd5,
    S_DONE     = 3'd6
  } state_t;

  localparam logic [7:0] C_MAX_N = 8'(MAX_N);

  state_t                   state_q, state_d;
  logic [7:0]               w_q, w_d, h_q, h_d, n_q, n_d;
  logic [MAX_N*MAX_N-1:0]   mask_q, mask_d;
  logic [7:0]               x_q, x_d, y_q, y_d, ky_q, ky_d, kx_q, kx_d;
  logic [7:0]               pix_q, pix_d, res_q, res_d;
  logic                     err_q, err_d;

  // Bits [31:24] of the parameter word carry nothing.
  logic w_unused;
  assign w_unused = ^i_parameters[31:24];

  logic             w_cur_en, w_later_en, w_last_pos, w_bad;
  logic [7:0]       w_r, w_row, w_col;
  logic signed [9:0] w_row_s, w_col_s;
  logic [15:0]      w_src_off, w_dst_off;
  int               w_cur_idx;

  // Window geometry: clamped source coordinates, mask lookup for the current
  // position and whether any enabled position follows it in this window.
  always_comb begin
    w_r        = (n_q - 8'd1) >> 1;
    w_row_s    = $signed({2'b00, y_q}) + $signed({2'b00, ky_q}) - $signed({2'b00, w_r});
    w_col_s    = $signed({2'b00, x_q}) + $signed({2'b00, kx_q}) - $signed({2'b00, w_r});
    if (w_row_s < 10'sd0)                               w_row = 8'd0;
    else if (w_row_s > $signed({2'b00, h_q - 8'd1}))    w_row = h_q - 8'd1;
    else                                                w_row = w_row_s[7:0];
    if (w_col_s < 10'sd0)                               w_col = 8'd0;
    else if (w_col_s > $signed({2'b00, w_q - 8'd1}))    w_col = w_q - 8'd1;
    else                                                w_col = w_col_s[7:0];
    w_src_off  = ({8'd0, w_row} * {8'd0, w_q}) + {8'd0, w_col};
    w_dst_off  = ({8'd0, y_q} * {8'd0, w_q}) + {8'd0, x_q};
    w_last_pos = (ky_q == n_q - 8'd1) && (kx_q == n_q - 8'd1);
    w_bad      = (w_q == 8'd0) || (h_q == 8'd0) || !n_q[0] || (n_q > C_MAX_N);
    w_cur_idx  = int'(ky_q) * MAX_N + int'(kx_q);
    w_cur_en   = 1'b0;
    w_later_en = 1'b0;
    for (int i = 0; i < MAX_N; i++) begin
      for (int j = 0; j < MAX_N; j++) begin
        if (i < int'(n_q) && j < int'(n_q)) begin
          if (i == int'(ky_q) && j == int'(kx_q))
            w_cur_en = mask_q[i*MAX_N + j];
          if ((i*MAX_N + j > w_cur_idx) && mask_q[i*MAX_N + j])
            w_later_en = 1'b1;
        end
      end
    end
  end

  // Next-state and datapath update for the pixel walk.
  always_comb begin
    state_d = state_q;
    w_d = w_q; h_d = h_q; n_d = n_q; mask_d = mask_q;
    x_d = x_q; y_d = y_q; ky_d = ky_q; kx_d = kx_q;
    pix_d = pix_q; res_d = res_q; err_d = err_q;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          w_d     = i_parameters[7:0];
          h_d     = i_parameters[15:8];
          n_d     = i_parameters[23:16];
          mask_d  = i_mask;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (w_bad) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          err_d = 1'b0;
          x_d = 8'd0; y_d = 8'd0; ky_d = 8'd0; kx_d = 8'd0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (w_cur_en) begin
          pix_d   = i_mem_data;
          state_d = S_PRESENT;
        end else if (w_last_pos) begin
          // Empty window: nothing to rank, result is zero.
          res_d   = 8'd0;
          state_d = S_WRITE;
        end else if (kx_q == n_q - 8'd1) begin
          kx_d = 8'd0;
          ky_d = ky_q + 8'd1;
        end else begin
          kx_d = kx_q + 8'd1;
        end
      end
      S_PRESENT: begin
        if (i_pix_ready) begin
          if (!w_later_en) begin
            state_d = S_WAIT_RES;
          end else begin
            state_d = S_FETCH;
            if (kx_q == n_q - 8'd1) begin
              kx_d = 8'd0;
              ky_d = ky_q + 8'd1;
            end else begin
              kx_d = kx_q + 8'd1;
            end
          end
        end
      end
      S_WAIT_RES: begin
        if (i_res_valid) begin
          res_d   = i_res_data;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        ky_d = 8'd0;
        kx_d = 8'd0;
        if (x_q == w_q - 8'd1) begin
          x_d = 8'd0;
          if (y_q == h_q - 8'd1) begin
            state_d = S_DONE;
          end else begin
            y_d     = y_q + 8'd1;
            state_d = S_FETCH;
          end
        end else begin
          x_d     = x_q + 8'd1;
          state_d = S_FETCH;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      w_q <= 8'd0; h_q <= 8'd0; n_q <= 8'd0;
      mask_q <= '0;
      x_q <= 8'd0; y_q <= 8'd0; ky_q <= 8'd0; kx_q <= 8'd0;
      pix_q <= 8'd0; res_q <= 8'd0; err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q <= w_d; h_q <= h_d; n_q <= n_d;
      mask_q <= mask_d;
      x_q <= x_d; y_q <= y_d; ky_q <= ky_d; kx_q <= kx_d;
      pix_q <= pix_d; res_q <= res_d; err_q <= err_d;
    end
  end

  // Output decode from registered state.
  always_comb begin
    o_running    = (state_q != S_IDLE);
    o_mem_w_en   = (state_q == S_WRITE);
    o_mem_w_data = res_q;
    o_pix_valid  = (state_q == S_PRESENT);
    o_pix_data   = pix_q;
    o_pix_last   = (state_q == S_PRESENT) && !w_later_en;
    o_done       = (state_q == S_DONE);
    o_err        = (state_q == S_DONE) && err_q;
    if (state_q == S_FETCH)      o_mem_addr = SRC_BASE + {16'd0, w_src_off};
    else if (state_q == S_WRITE) o_mem_addr = DST_BASE + {16'd0, w_dst_off};
    else                         o_mem_addr = 32'd0;
  end

endmodule
`default_nettype wire
